// File: rtl/hier_rr_dispatch_node.sv
// hier_rr_dispatch_node: interior node of a hierarchy tree. Fans one input
// stream out to NUM_CH child channels, each behind a one-entry output register.
// MODE=0 dispatches round-robin (one channel per beat), MODE=1 broadcasts to
// every enabled channel. Optional per-channel accepted-beat counters are built
// when the macro HIER_DISPATCH_STATS_EN is defined; otherwise ch_cnt is 0.
//
// Handshake: a beat moves across a port on a rising edge where valid & ready
// are both 1. Producers hold valid and data stable until accepted. in_ready is
// never a function of in_valid. A full slot whose child is ready in the same
// cycle counts as free, so draining and refilling can happen on one edge.
module hier_rr_dispatch_node #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]  ch_cnt
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  sel;
  logic              sel_found;
  logic [NUM_CH-1:0] can_take;
  logic [NUM_CH-1:0] load;
  logic              accept;

  // Free-slot mask and round-robin search starting at ptr.
  always_comb begin
    can_take  = ch_en & (~out_valid | out_ready);
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_CH;
      if (!sel_found && can_take[idx]) begin
        sel_found = 1'b1;
        sel       = PTR_W'(idx);
      end
    end
  end

  // Input readiness and the per-channel load mask for the accepted beat.
  always_comb begin
    in_ready = 1'b0;
    load     = '0;
    if (!rst) begin
      if (MODE == 0) in_ready = sel_found;
      else           in_ready = (|ch_en) && (can_take == ch_en);
    end
    accept = in_valid & in_ready;
    if (accept) begin
      if (MODE == 0) load = NUM_CH'(1) << sel;
      else           load = ch_en;
    end
  end

  // Round-robin pointer: advances past the loaded channel, wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == 0 && accept) begin
      if (int'(sel) == NUM_CH - 1) ptr <= '0;
      else                         ptr <= sel + PTR_W'(1);
    end
  end

  // One-entry output registers: load wins, else drain clears, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          out_valid[k]                   <= 1'b1;
          out_data[k*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k]                   <= 1'b0;
        end
      end
    end
  end

`ifdef HIER_DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  // Saturating count of beats loaded into each channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k] && (cnt_q[k] != {CNT_W{1'b1}})) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign ch_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign ch_cnt = '0;
`endif

endmodule

// File: tb/tb_hier_rr_dispatch_node.sv
// Directed bench for hier_rr_dispatch_node: a round-robin node (5 channels),
// a broadcast node (5 channels) and a single-channel node with 2-bit counters.
module tb_hier_rr_dispatch_node;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- round-robin node ----------------
  logic        v0 = 1'b0, r0;
  logic [7:0]  d0 = '0;
  logic [4:0]  en0 = 5'h1f, ordy0 = 5'h1f, ov0;
  logic [39:0] od0;
  logic [79:0] cnt0;

  hier_rr_dispatch_node #(.NUM_CH(5), .DATA_W(8), .MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .ch_en(en0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .ch_cnt(cnt0));

  // ---------------- broadcast node ----------------
  logic        v1 = 1'b0, r1;
  logic [7:0]  d1 = '0;
  logic [4:0]  en1 = 5'h1f, ordy1 = 5'h1f, ov1;
  logic [39:0] od1;
  logic [79:0] cnt1;

  hier_rr_dispatch_node #(.NUM_CH(5), .DATA_W(8), .MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .ch_en(en1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .ch_cnt(cnt1));

  // ---------------- single-channel node, 2-bit counters ----------------
  logic       v2 = 1'b0, r2;
  logic [7:0] d2 = '0;
  logic [0:0] en2 = 1'b1, ordy2 = 1'b1, ov2;
  logic [7:0] od2;
  logic [1:0] cnt2;

  hier_rr_dispatch_node #(.NUM_CH(1), .DATA_W(8), .MODE(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .ch_en(en2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .ch_cnt(cnt2));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] slot(input logic [39:0] bus, input int k);
    return bus[k*8 +: 8];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    #1;
    check("in_ready_in_rst", r0, 1'b0);
    tick(); tick();
    check("rst_valid", ov0, 5'b0);
    check("rst_data", od0, 40'h0);
    check("rst_cnt", cnt0, 80'h0);
    check("rst_valid_bc", ov1, 5'b0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", r0, 1'b1);

    // 1: ten beats round-robin, all enabled and ready
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      v0 = 1'b1; d0 = e;
      #1;
      check("rr_ready", r0, 1'b1);
      tick();
      check($sformatf("rr_valid_%0d", i), ov0, 5'b1 << (i % 5));
      check($sformatf("rr_data_%0d", i), slot(od0, i % 5), e);
    end
    v0 = 1'b0;
    tick();
    check("rr_drained", ov0, 5'b0);
`ifdef HIER_DISPATCH_STATS_EN
    check("rr_cnt_ch0", cnt0[15:0], 16'd2);
`else
    check("rr_cnt_off", cnt0, 80'h0);
`endif

    // 2: ch2 stalled; later beat skips ch2 and lands in ch3
    ordy0 = 5'b11011;
    for (int i = 0; i < 7; i++) begin
      v0 = 1'b1; d0 = 8'h20 + 8'(i);
      tick();
    end
    check("skip_pre_valid", ov0, 5'b00110);
    check("skip_hold_ch2", slot(od0, 2), 8'h22);
    d0 = 8'h27;
    tick();
    check("skip_valid", ov0, 5'b01100);
    check("skip_ch3", slot(od0, 3), 8'h27);
    d0 = 8'h28;
    tick();
    check("skip_ch4", ov0, 5'b10100);
    check("skip_ch4_data", slot(od0, 4), 8'h28);
    check("skip_hold_ch2b", slot(od0, 2), 8'h22);
    v0 = 1'b0; ordy0 = 5'h1f;
    tick();
    check("skip_drained", ov0, 5'b0);

    // 4: buffered beats, then ch_en all zero for 5 cycles
    ordy0 = 5'b0;
    v0 = 1'b1; d0 = 8'h40; tick();
    d0 = 8'h41; tick();
    check("en0_pre", ov0, 5'b00011);
    en0 = 5'b0; d0 = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("en0_ready", r0, 1'b0);
      tick();
      check("en0_noload", ov0, 5'b00011);
    end
    check("en0_hold_ch0", slot(od0, 0), 8'h40);
    v0 = 1'b0; ordy0 = 5'h1f;
    tick();
    check("en0_drain", ov0, 5'b0);
    en0 = 5'h1f;

    // 5: reset with three channels full; next beat goes to ch0
    ordy0 = 5'b0;
    for (int i = 0; i < 3; i++) begin
      v0 = 1'b1; d0 = 8'h50 + 8'(i);
      tick();
    end
    check("mid_pre", ov0, 5'b11100);
    v0 = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_ready", r0, 1'b0);
    tick();
    check("mid_valid", ov0, 5'b0);
    check("mid_data", od0, 40'h0);
    rst = 1'b0; ordy0 = 5'h1f;
    v0 = 1'b1; d0 = 8'h60;
    tick();
    v0 = 1'b0;
    check("mid_next_ch0", ov0, 5'b00001);
    check("mid_next_data", slot(od0, 0), 8'h60);

    // 3: broadcast to 5'b10101
    en1 = 5'b10101; ordy1 = 5'h1f;
    v1 = 1'b1; d1 = 8'hA5;
    #1;
    check("bc_ready", r1, 1'b1);
    tick();
    v1 = 1'b0;
    check("bc_valid", ov1, 5'b10101);
    check("bc_data", od1, 40'hA5_00_A5_00_A5);
    ordy1 = 5'b01111;
    #1;
    check("bc_block", r1, 1'b0);
    tick();
    check("bc_partial_drain", ov1, 5'b10000);
    check("bc_block2", r1, 1'b0);
    // ch4 disabled while holding a beat: beat kept, others refill
    en1 = 5'b00101;
    #1;
    check("bc_en_fall_ready", r1, 1'b1);
    v1 = 1'b1; d1 = 8'h5A;
    tick();
    v1 = 1'b0;
    check("bc_en_fall_valid", ov1, 5'b10101);
    check("bc_en_fall_data", od1, 40'hA5_00_5A_00_5A);
    ordy1 = 5'h1f;
    tick();
    check("bc_drain", ov1, 5'b0);

    // 6: single channel, five beats, 2-bit saturating counter
    check("one_cnt_init", cnt2, 2'd0);
    for (int i = 0; i < 5; i++) begin
      v2 = 1'b1; d2 = 8'h70 + 8'(i);
      #1;
      check("one_ready", r2, 1'b1);
      tick();
      check("one_data", od2, 8'h70 + 8'(i));
    end
    v2 = 1'b0;
    tick();
    check("one_drain", ov2, 1'b0);
`ifdef HIER_DISPATCH_STATS_EN
    check("one_cnt_sat", cnt2, 2'd3);
`else
    check("one_cnt_off", cnt2, 2'd0);
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
